// File: rtl/out2in_pkg.sv
// Shared helpers for the multi-channel out-to-in merge FIFO.
package out2in_pkg;

  // Width of the channel tag: one bit minimum, so NCHAN=1 still has a tag field.
  function automatic int tagWidth(input int nchan);
    return (nchan <= 1) ? 1 : $clog2(nchan);
  endfunction

endpackage

// File: rtl/out2in_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible channel at or after rr_ptr_i.
module out2in_rr_arbiter
  import out2in_pkg::*;
#(
  parameter  int NCHAN = 4,
  localparam int CHW   = tagWidth(NCHAN)
) (
  input  logic [NCHAN-1:0] eligible_i,
  input  logic [CHW-1:0]   rr_ptr_i,
  input  logic             enable_i,
  output logic [NCHAN-1:0] grant_o,
  output logic [CHW-1:0]   grant_idx_o,
  output logic             grant_valid_o
);

  logic [CHW:0]   cand;
  logic [CHW-1:0] candIdx;
  logic           found;

  // Scan rr_ptr, rr_ptr+1, ... modulo NCHAN and take the first eligible one.
  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    found         = 1'b0;
    cand          = '0;
    candIdx       = '0;
    for (int k = 0; k < NCHAN; k++) begin
      cand = {1'b0, rr_ptr_i} + (CHW+1)'(k);
      if (cand >= (CHW+1)'(NCHAN)) begin
        cand = cand - (CHW+1)'(NCHAN);
      end
      candIdx = cand[CHW-1:0];
      if (!found && eligible_i[candIdx]) begin
        found       = 1'b1;
        grant_idx_o = candIdx;
      end
    end
    grant_valid_o = found && enable_i;
    if (grant_valid_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/out2in_arb_fifo.sv
// Merges NCHAN first/deq sources into one enq sink through a tagged DEPTH-entry FIFO.
module out2in_arb_fifo
  import out2in_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCHAN = 4,
  parameter  int DEPTH = 4,
  localparam int CHW   = tagWidth(NCHAN),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCHAN*WIDTH-1:0] in_first,
  input  logic [NCHAN-1:0]       in_first__RDY,
  input  logic [NCHAN-1:0]       in_deq__RDY,
  output logic [NCHAN-1:0]       in_deq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  output logic [CHW-1:0]         out_enq_tag,
  input  logic                   out_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [CNTW-1:0]        occupancy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CHW-1:0]   tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NCHAN-1:0] eligible;
  logic [NCHAN-1:0] grant;
  logic [CHW-1:0]   grant_idx;
  logic             push_allowed;
  logic             push;
  logic             pop;

  assign eligible     = in_first__RDY & in_deq__RDY;
  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot early.
  assign push_allowed = (count_q < CNTW'(DEPTH)) && !nRST;
  assign pop          = (count_q != '0) && out_enq__RDY && !nRST;

  out2in_rr_arbiter #(.NCHAN(NCHAN)) u_arb (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_ptr_q),
    .enable_i      (push_allowed),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (push)
  );

  assign in_deq__ENA  = grant;
  assign out_enq__ENA = pop;
  assign out_enq_v    = mem_q[rd_ptr_q].data;
  assign out_enq_tag  = mem_q[rd_ptr_q].tag;
  assign occupancy    = count_q;

  // Next-state for pointers, count and the round-robin start position.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (grant_idx == CHW'(NCHAN - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset; reset discards all buffered words.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage is never reset; the granted channel's head is written with its tag.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{tag: grant_idx, data: in_first[int'(grant_idx)*WIDTH +: WIDTH]};
    end
  end

endmodule

// File: tb/tb_out2in_arb_fifo.sv
// Self-checking bench for out2in_arb_fifo with a queue-based reference model.
module tb_out2in_arb_fifo;

  localparam int WIDTH = 32;
  localparam int NCHAN = 4;
  localparam int DEPTH = 4;
  localparam int CHW   = 2;
  localparam int CNTW  = 3;

  logic                   CLK = 1'b0;
  logic                   nRST = 1'b1;
  logic [NCHAN*WIDTH-1:0] in_first = '0;
  logic [NCHAN-1:0]       in_first__RDY = '0;
  logic [NCHAN-1:0]       in_deq__RDY = '0;
  logic [NCHAN-1:0]       in_deq__ENA;
  logic [WIDTH-1:0]       out_enq_v;
  logic [CHW-1:0]         out_enq_tag;
  logic                   out_enq__RDY = 1'b0;
  logic                   out_enq__ENA;
  logic [CNTW-1:0]        occupancy;

  out2in_arb_fifo #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_first      (in_first),
    .in_first__RDY (in_first__RDY),
    .in_deq__RDY   (in_deq__RDY),
    .in_deq__ENA   (in_deq__ENA),
    .out_enq_v     (out_enq_v),
    .out_enq_tag   (out_enq_tag),
    .out_enq__RDY  (out_enq__RDY),
    .out_enq__ENA  (out_enq__ENA),
    .occupancy     (occupancy)
  );

  // Free-running 10-unit clock.
  always #5 CLK = ~CLK;

  typedef struct {
    int               tag;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] head [NCHAN];
  int               mRr;

  logic             rstReq;
  logic [NCHAN-1:0] firstRdy, deqRdy;
  logic             sinkRdy;

  int               checks, errors, cycleNo;
  logic [NCHAN-1:0] expDeq;
  int               expG;
  logic             expEnq;

  logic [NCHAN-1:0] sDeq;
  logic             sEnq;
  logic [CNTW-1:0]  sOcc;
  logic [CHW-1:0]   sTag;
  logic [WIDTH-1:0] sData;

  int               deqCount, enqCount, firstDeq, firstEnq, lastEnq;
  int               enqTags[$];
  logic [WIDTH-1:0] enqData[$];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cycleNo);
    end
  endtask

  task automatic clearStats();
    deqCount = 0;
    enqCount = 0;
    firstDeq = -1;
    firstEnq = -1;
    lastEnq  = -1;
    enqTags.delete();
    enqData.delete();
  endtask

  // Drive the pins from the stimulus controls; reset assertion empties the model at once.
  task automatic applyStimulus();
    nRST          = rstReq;
    in_first__RDY = firstRdy;
    in_deq__RDY   = deqRdy;
    out_enq__RDY  = sinkRdy;
    for (int i = 0; i < NCHAN; i++) in_first[i*WIDTH +: WIDTH] = head[i];
    if (rstReq) begin
      mq.delete();
      mRr = 0;
    end
  endtask

  // Work out what this cycle must look like, then compare against the pins.
  task automatic checkOutput();
    logic [NCHAN-1:0] elig;
    int c;
    elig   = firstRdy & deqRdy;
    expDeq = '0;
    expG   = -1;
    if (!rstReq && mq.size() < DEPTH) begin
      for (int k = 0; k < NCHAN; k++) begin
        c = (mRr + k) % NCHAN;
        if (expG < 0 && elig[c]) expG = c;
      end
    end
    if (expG >= 0) expDeq[expG] = 1'b1;
    expEnq = !rstReq && sinkRdy && (mq.size() > 0);

    sDeq  = in_deq__ENA;
    sEnq  = out_enq__ENA;
    sOcc  = occupancy;
    sTag  = out_enq_tag;
    sData = out_enq_v;

    checkVal("in_deq__ENA", 64'(sDeq), 64'(expDeq));
    checkVal("out_enq__ENA", 64'(sEnq), 64'(expEnq));
    checkVal("occupancy", 64'(sOcc), 64'(mq.size()));
    if (mq.size() > 0) begin
      checkVal("out_enq_tag", 64'(sTag), 64'(mq[0].tag));
      checkVal("out_enq_v", 64'(sData), 64'(mq[0].data));
    end

    if (sDeq != '0) begin
      deqCount++;
      if (firstDeq < 0) firstDeq = cycleNo;
    end
    if (sEnq) begin
      enqCount++;
      if (firstEnq < 0) firstEnq = cycleNo;
      lastEnq = cycleNo;
      enqTags.push_back(int'(sTag));
      enqData.push_back(sData);
    end
  endtask

  // Advance the model across the rising edge: pop the head, append the granted word.
  task automatic modelStep();
    ent_t e;
    if (!rstReq) begin
      if (expEnq) void'(mq.pop_front());
      if (expG >= 0) begin
        e.tag  = expG;
        e.data = head[expG];
        mq.push_back(e);
        head[expG] = head[expG] + 1;
        mRr = (expG + 1) % NCHAN;
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge CLK);
    applyStimulus();
    #1;
    checkOutput();
    @(posedge CLK);
    modelStep();
    cycleNo++;
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    stepCycle();
    stepCycle();
    rstReq = 1'b0;
  endtask

  // Directed phases followed by a long randomized run, then the summary.
  initial begin
    logic [WIDTH-1:0] startData;
    checks  = 0;
    errors  = 0;
    cycleNo = 0;
    mRr     = 0;
    for (int i = 0; i < NCHAN; i++) head[i] = WIDTH'((i + 1) << 24);
    clearStats();

    // Reset with every source ready: no strobes, empty FIFO, then ch0 first.
    rstReq   = 1'b1;
    firstRdy = '1;
    deqRdy   = '1;
    sinkRdy  = 1'b1;
    repeat (3) stepCycle();
    checkVal("reset deq strobe", 64'(sDeq), 64'(0));
    checkVal("reset enq strobe", 64'(sEnq), 64'(0));
    checkVal("reset occupancy", 64'(sOcc), 64'(0));
    rstReq = 1'b0;
    stepCycle();
    checkVal("first grant ch0", 64'(sDeq), 64'(4'b0001));

    // Channel 2 alone streams 0x10..0x17 into an always-ready sink.
    doReset();
    head[2]  = 32'h10;
    deqRdy   = '1;
    sinkRdy  = 1'b1;
    clearStats();
    repeat (12) begin
      firstRdy = (head[2] <= 32'h17) ? 4'b0100 : 4'b0000;
      stepCycle();
    end
    checkVal("ch2 enq count", 64'(enqCount), 64'(8));
    checkVal("ch2 first latency", 64'(firstEnq - firstDeq), 64'(1));
    checkVal("ch2 back-to-back", 64'(lastEnq - firstEnq), 64'(7));
    for (int k = 0; k < 8 && k < enqData.size(); k++) begin
      checkVal("ch2 tag", 64'(enqTags[k]), 64'(2));
      checkVal("ch2 data", 64'(enqData[k]), 64'(32'h10 + k));
    end

    // All channels always eligible: tags must rotate 0,1,2,3.
    doReset();
    firstRdy = '1;
    sinkRdy  = 1'b1;
    clearStats();
    repeat (20) stepCycle();
    checkVal("rr enough words", 64'(enqCount >= 16), 64'(1));
    for (int k = 0; k < 16 && k < enqTags.size(); k++) begin
      checkVal("rr tag order", 64'(enqTags[k]), 64'(k % 4));
    end

    // Sink stalled while ch1 streams: exactly DEPTH words accepted, then drain and refill.
    doReset();
    firstRdy  = 4'b0010;
    sinkRdy   = 1'b0;
    startData = head[1];
    clearStats();
    repeat (10) stepCycle();
    checkVal("full deq count", 64'(deqCount), 64'(4));
    checkVal("full occupancy", 64'(sOcc), 64'(4));
    checkVal("full deq blocked", 64'(sDeq), 64'(0));
    sinkRdy = 1'b1;
    clearStats();
    repeat (8) stepCycle();
    checkVal("refill after pop", 64'(firstDeq - firstEnq), 64'(1));
    for (int k = 0; k < 4 && k < enqData.size(); k++) begin
      checkVal("drain order", 64'(enqData[k]), 64'(startData + k));
    end

    // Hold two entries, then push and pop every cycle across pointer wraps.
    doReset();
    firstRdy  = 4'b0001;
    sinkRdy   = 1'b0;
    startData = head[0];
    repeat (2) stepCycle();
    sinkRdy = 1'b1;
    clearStats();
    repeat (20) begin
      stepCycle();
      checkVal("steady occupancy", 64'(sOcc), 64'(2));
    end
    checkVal("steady enq count", 64'(enqCount), 64'(20));
    for (int k = 0; k < enqData.size(); k++) begin
      checkVal("steady data seq", 64'(enqData[k]), 64'(startData + k));
    end

    // Reset with three words buffered: strobes drop, nothing stale comes out later.
    doReset();
    firstRdy = 4'b1000;
    sinkRdy  = 1'b0;
    repeat (3) stepCycle();
    rstReq  = 1'b1;
    sinkRdy = 1'b1;
    stepCycle();
    checkVal("midrst deq strobe", 64'(sDeq), 64'(0));
    checkVal("midrst enq strobe", 64'(sEnq), 64'(0));
    checkVal("midrst occupancy", 64'(sOcc), 64'(0));
    stepCycle();
    rstReq   = 1'b0;
    firstRdy = '0;
    clearStats();
    repeat (4) stepCycle();
    checkVal("no stale enq", 64'(enqCount), 64'(0));
    checkVal("post-rst occupancy", 64'(sOcc), 64'(0));

    // Randomized traffic with varying sink pressure and occasional resets.
    for (int blk = 0; blk < 5; blk++) begin
      repeat (300) begin
        rstReq   = ($urandom_range(0, 199) == 0);
        firstRdy = NCHAN'($urandom);
        deqRdy   = NCHAN'($urandom);
        sinkRdy  = ($urandom_range(0, 4) < blk + 1);
        stepCycle();
      end
    end
    rstReq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
